// File: rtl/pixel_dut_pkg.sv
// Shared types and constants for the pixel-stream edge engine.
package pixel_dut_pkg;

    localparam int unsigned SIZE_W   = 12;
    localparam int unsigned LINE_MAX = 4096;
    localparam int unsigned AREA_W   = 2 * SIZE_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } t_engine_state;

    typedef logic [SIZE_W-1:0] t_size;
    typedef logic [AREA_W-1:0] t_area;

    // Frame area at full width so the largest frame never truncates.
    function automatic t_area frame_area(input t_size sx, input t_size sy);
        return t_area'(sx) * t_area'(sy);
    endfunction

endpackage

// File: rtl/dut_engine.sv
// Frame engine: IDLE/RUN/DONE control, x/y/area counters and the edge datapath.
// Optional vertical edge term and line buffer enabled by PIXEL_DUT_VERT_EDGE_EN.
module dut_engine
    import pixel_dut_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  logic  size_zero,
    input  t_size size_x,
    input  t_size size_y,
    input  logic  pixel_in,
    output logic  idle,
    output logic  pixel_out,
    output logic  pixel_valid
);

    t_engine_state state_q, state_d;
    t_size         x_q, x_d;
    t_size         y_q, y_d;
    t_area         cnt_q, cnt_d;
    t_area         last_idx;
    logic          prev_q, prev_d;
    logic          out_q, out_d;
    logic          valid_q, valid_d;
    logic          left;
    logic          edge_bit;

    // Index of the final pixel; only used in RUN, where both sizes are non-zero.
    assign last_idx = frame_area(size_x, size_y) - t_area'(1);

    // Left neighbour is zero at the start of every row.
    assign left = (x_q == '0) ? 1'b0 : prev_q;

`ifdef PIXEL_DUT_VERT_EDGE_EN
    localparam int unsigned LB_AW = $clog2(LINE_MAX);

    logic             line_q [LINE_MAX];
    logic             in_line;
    logic             above;
    logic [LB_AW-1:0] x_idx;

    // Columns beyond the buffer depth see no row above.
    assign in_line  = (32'(x_q) < LINE_MAX);
    assign x_idx    = x_q[LB_AW-1:0];
    assign above    = (y_q != '0 && in_line) ? line_q[x_idx] : 1'b0;
    assign edge_bit = (pixel_in ^ left) | (pixel_in ^ above);

    // Line buffer holds the previous row; contents need no reset since row 0 ignores it.
    always_ff @(posedge clk) begin
        if (state_q == RUN && in_line) begin
            line_q[x_idx] <= pixel_in;
        end
    end
`else
    assign edge_bit = pixel_in ^ left;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    // Next-state, counter advance and output selection.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                    prev_d  = 1'b0;
                    state_d = size_zero ? DONE : RUN;
                end
            end
            RUN: begin
                out_d   = edge_bit;
                valid_d = 1'b1;
                prev_d  = pixel_in;
                cnt_d   = cnt_q + t_area'(1);
                if (x_q == size_x - t_size'(1)) begin
                    x_d = '0;
                    y_d = y_q + t_size'(1);
                end else begin
                    x_d = x_q + t_size'(1);
                end
                if (cnt_q == last_idx) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign idle        = (state_q == IDLE);
    assign pixel_out   = out_q;
    assign pixel_valid = valid_q;

endmodule

// File: rtl/pixel_dut_top.sv
// Pixel-stream engine top: latches frame size on an accepted start and wraps dut_engine.
// Build option PIXEL_DUT_VERT_EDGE_EN adds the vertical edge term inside the engine.
module pixel_dut_top
    import pixel_dut_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE_W-1:0] size_x,
    input  logic [SIZE_W-1:0] size_y,
    input  logic              pixel_in,
    output logic              pixel_out,
    output logic              pixel_valid
);

    logic  idle;
    logic  accept;
    logic  size_zero;
    t_size size_x_q;
    t_size size_y_q;

    assign accept    = idle & start;
    assign size_zero = (size_x == '0) || (size_y == '0);

    // Frame size is captured only when a start is accepted in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            size_x_q <= '0;
            size_y_q <= '0;
        end else if (accept) begin
            size_x_q <= size_x;
            size_y_q <= size_y;
        end
    end

    dut_engine u_engine (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .size_zero   (size_zero),
        .size_x      (size_x_q),
        .size_y      (size_y_q),
        .pixel_in    (pixel_in),
        .idle        (idle),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid)
    );

endmodule

// File: tb/tb_pixel_dut_top.sv
// Self-checking bench for pixel_dut_top; honours PIXEL_DUT_VERT_EDGE_EN like the RTL.
module tb_pixel_dut_top;
    import pixel_dut_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [SIZE_W-1:0] size_x = '0;
    logic [SIZE_W-1:0] size_y = '0;
    logic              pixel_in = 1'b0;
    logic              pixel_out;
    logic              pixel_valid;

    int checks = 0;
    int errors = 0;

    bit pix  [8192];
    bit expv [8192];

    always #5 clk = ~clk;

    pixel_dut_top dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .size_x      (size_x),
        .size_y      (size_y),
        .pixel_in    (pixel_in),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic got, input logic want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, got, want);
        end
    endtask

    // Reference: walk the frame as a 2-D image and apply the edge rule directly.
    function automatic void model(input int sx, input int sy);
        for (int yy = 0; yy < sy; yy++) begin
            for (int xx = 0; xx < sx; xx++) begin
                bit cur, lft, e;
                cur = pix[yy * sx + xx];
                lft = 1'b0;
                if (xx > 0) lft = pix[yy * sx + xx - 1];
                e = cur ^ lft;
`ifdef PIXEL_DUT_VERT_EDGE_EN
                begin
                    bit abv;
                    abv = 1'b0;
                    if (yy > 0 && xx < LINE_MAX) abv = pix[(yy - 1) * sx + xx];
                    e = e | (cur ^ abv);
                end
`endif
                expv[yy * sx + xx] = e;
            end
        end
    endfunction

    function automatic void rand_pix(input int n);
        for (int i = 0; i < n; i++) pix[i] = 1'($urandom_range(0, 1));
    endfunction

    // Starts a frame from IDLE, streams pix[], checks every output cycle and the return to idle.
    // With noisy set, start and the size inputs toggle randomly while the frame is busy.
    task automatic run_frame(input int sx, input int sy, input bit noisy, input string tag);
        int n;
        n      = sx * sy;
        start  = 1'b1;
        size_x = sx[SIZE_W-1:0];
        size_y = sy[SIZE_W-1:0];
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            pixel_in = pix[i];
            if (noisy) begin
                start  = 1'($urandom_range(0, 1));
                size_x = SIZE_W'($urandom);
                size_y = SIZE_W'($urandom);
            end
            tick();
            chk($sformatf("%s valid[%0d]", tag, i), pixel_valid, 1'b1);
            chk($sformatf("%s out[%0d]", tag, i), pixel_out, expv[i]);
        end
        // DONE cycle (or the zero-size frame's DONE): a start here must be ignored.
        chk($sformatf("%s valid_done", tag), pixel_valid, (n > 0) ? 1'b1 : 1'b0);
        start    = noisy;
        pixel_in = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        chk($sformatf("%s valid_idle", tag), pixel_valid, 1'b0);
        chk($sformatf("%s out_idle", tag), pixel_out, 1'b0);
        if (noisy) begin
            tick();
            chk($sformatf("%s no_restart", tag), pixel_valid, 1'b0);
        end
    endtask

    initial begin
        int sx, sy;
        bit [7:0] p3_in, p3_out;

        // Reset state.
        #2;
        chk("reset_valid", pixel_valid, 1'b0);
        chk("reset_out", pixel_out, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 40x40 all ones: out is 1 only at row start.
        for (int i = 0; i < 1600; i++) pix[i] = 1'b1;
        model(40, 40);
        run_frame(40, 40, 1'b0, "ones40");

        // 4x2 directed pattern.
        p3_in  = 8'b1001_0110;
        p3_out = 8'b1101_0101;
        for (int i = 0; i < 8; i++) pix[i] = p3_in[7 - i];
        model(4, 2);
`ifndef PIXEL_DUT_VERT_EDGE_EN
        for (int i = 0; i < 8; i++) expv[i] = p3_out[7 - i];
`endif
        run_frame(4, 2, 1'b0, "pat4x2");

        // 2x2 vertical pattern.
        pix[0] = 1'b0; pix[1] = 1'b0; pix[2] = 1'b1; pix[3] = 1'b1;
        model(2, 2);
`ifdef PIXEL_DUT_VERT_EDGE_EN
        expv[0] = 1'b0; expv[1] = 1'b0; expv[2] = 1'b1; expv[3] = 1'b1;
`endif
        run_frame(2, 2, 1'b0, "pat2x2");

        // Zero-size frames go straight through DONE.
        run_frame(0, 5, 1'b1, "zero_x");
        run_frame(7, 0, 1'b0, "zero_y");

        // Random frames, some with start/size noise while busy; back-to-back by construction.
        for (int f = 0; f < 6; f++) begin
            sx = $urandom_range(1, 12);
            sy = $urandom_range(1, 8);
            rand_pix(sx * sy);
            model(sx, sy);
            run_frame(sx, sy, 1'($urandom_range(0, 1)), $sformatf("rand%0d", f));
        end

        // Degenerate shapes.
        rand_pix(9);
        model(1, 9);
        run_frame(1, 9, 1'b1, "col1x9");
        rand_pix(13);
        model(13, 1);
        run_frame(13, 1, 1'b0, "row13x1");

        // Area above 12 bits must not truncate.
        rand_pix(5000);
        model(100, 50);
        run_frame(100, 50, 1'b0, "big100x50");

        // Reset mid-frame aborts, no residual valid.
        start  = 1'b1;
        size_x = 12'd10;
        size_y = 12'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            pixel_in = 1'($urandom_range(0, 1));
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", pixel_valid, 1'b0);
        chk("midrst_out", pixel_out, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            pixel_in = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("postrst_valid[%0d]", i), pixel_valid, 1'b0);
            chk($sformatf("postrst_out[%0d]", i), pixel_out, 1'b0);
        end
        rand_pix(15);
        model(5, 3);
        run_frame(5, 3, 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
